writeback_unit: RTL
===================

# writeback_unit

Write-side companion of the register file. Collects single-cycle ALU results and in-order data-memory load returns and drives the register file's write port (RegWrite, write_reg_addr, write_reg_data). Tracks outstanding loads by destination register and flags read-after-write and write-after-write hazards to issue logic.

## Interface
- REG_ADDR_WIDTH, 5, register index width
- REG_DATA_WIDTH, 64, register data width
- PQ_DEPTH, 4, pending-load queue entries (power of 2)
- RB_DEPTH, 2, load-return buffer entries (power of 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  REG_ADDR_WIDTH  ALU destination
- alu_data  in  REG_DATA_WIDTH  ALU result
- load_issue  in  1  load issued to memory this cycle
- load_issue_rd  in  REG_ADDR_WIDTH  load destination
- issue_stall  out  1  pending queue full; load_issue must not be asserted
- mem_valid  in  1  load data returned (in issue order)
- mem_data  in  REG_DATA_WIDTH  returned data
- mem_ready  out  1  return buffer not full
- read_reg_addr_1, read_reg_addr_2  in  REG_ADDR_WIDTH  source registers being read by decode
- hazard_1, hazard_2  out  1  source register has a write not yet committed
- hazard_rd  in  REG_ADDR_WIDTH  destination of the instruction in decode
- hazard_waw  out  1  hazard_rd has a pending load
- RegWrite  out  1  register file write enable, registered
- write_reg_addr  out  REG_ADDR_WIDTH  registered
- write_reg_data  out  REG_DATA_WIDTH  registered
- proto_err  out  1  sticky: mem_valid with no load pending

## Operation
- Pending queue (PQ): FIFO of load rd. Push on load_issue. Pop on mem handshake (mem_valid && mem_ready). Handshake pops the PQ head and pushes {rd, mem_data} into the return buffer (RB).
- Write-port selection each cycle: alu_valid wins; otherwise RB head if non-empty, which pops it. The selected {rd, data} is registered into the output stage. RegWrite = selected && rd != 0. rd 0 is consumed with no write.
- ALU results are never buffered; ALU is never stalled.
- issue_stall = PQ full. A pop and a push in the same cycle on a full PQ are both accepted; issue_stall is still asserted that cycle.
- mem_ready = RB not full. An RB pop and a handshake in the same cycle on a full RB are not allowed, because mem_ready is low.
- mem_valid with PQ empty: data dropped, proto_err set until reset.
- hazard_n = read_reg_addr_n != 0 && it matches any valid PQ entry, any valid RB entry, or the output stage (RegWrite && write_reg_addr). The output stage is included because the register file reads and writes on the same edge.
- hazard_waw = hazard_rd != 0 && it matches any valid PQ or RB entry. Decode stalls an ALU op on this, so an older load cannot overwrite a younger ALU result.
- Hazards are combinational from inputs and state.

## Timing
- Reset values: RegWrite 0, write_reg_addr 0, write_reg_data 0, issue_stall 0, mem_ready 1, hazards 0, proto_err 0. PQ and RB are empty.
- Reset asserted mid-operation discards all pending loads and buffered data. No write occurs on the following edges until new inputs arrive.
- ALU latency: alu_valid in cycle t gives RegWrite in cycle t+1.
- Load latency, uncontested: handshake in cycle t puts the entry in RB in cycle t+1 and gives RegWrite in cycle t+2.
- Each cycle of alu_valid delays the RB head by one cycle.
- PQ and RB pointers wrap modulo depth. Occupancy counters are one bit wider than the pointers.

## Test plan
- Reset, then alu_valid with rd=5, data=0x1234 in cycle 1 -> RegWrite=1, addr=5, data=0x1234 in cycle 2. Reset values are checked first.
- load_issue rd=7, mem_valid data=0xABCD three cycles later -> hazard_1 high for read_reg_addr_1=7 from issue until RegWrite drops. Write happens 2 cycles after the handshake.
- Back-to-back: mem handshake and alu_valid (rd=3) in the same cycle -> ALU written first, load written the next cycle, no data lost.
- Issue 4 loads -> issue_stall=1. A 5th issue together with a mem return is accepted. The returns write rd in issue order with matching data.
- Hold alu_valid for 4 cycles while 3 loads return -> mem_ready drops after 2 buffered returns, and the memory holds its data. All loads are eventually written in order.
- mem_valid with nothing pending -> proto_err=1, no RegWrite. Separately, a load or ALU result with rd=0 -> no RegWrite, and hazard_1 stays 0 for address 0.

Source files
------------

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Purpose:
//   Write-side companion of the register file. Merges single-cycle ALU results
//   with in-order data-memory load returns onto the register file's single
//   write port. Outstanding loads are tracked by destination register so issue
//   logic can be told about read-after-write and write-after-write hazards.
//
// Structure:
//   pending queue (PQ) : FIFO of destination registers of loads issued to memory
//   return buffer (RB) : FIFO of {rd, data} for loads whose data has returned
//   output stage       : registered write port (RegWrite / addr / data)
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   alu_valid/alu_rd/alu_data  ALU result, never stalled, has write priority
//   load_issue/load_issue_rd   load issued to memory, pushes the PQ
//   issue_stall                PQ full, issue logic must hold off loads
//   mem_valid/mem_data         in-order load return
//   mem_ready                  RB not full, memory must hold its data when low
//   read_reg_addr_1/2          decode source registers
//   hazard_1/2                 source register has an uncommitted write
//   hazard_rd/hazard_waw       decode destination has a pending load
//   RegWrite/write_reg_addr/
//   write_reg_data             registered register-file write port
//   proto_err                  sticky: memory returned data with no load pending
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 64,
  parameter int PQ_DEPTH       = 4,
  parameter int RB_DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_DATA_WIDTH-1:0] alu_data,
  input  logic                      load_issue,
  input  logic [REG_ADDR_WIDTH-1:0] load_issue_rd,
  output logic                      issue_stall,
  input  logic                      mem_valid,
  input  logic [REG_DATA_WIDTH-1:0] mem_data,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] read_reg_addr_1,
  input  logic [REG_ADDR_WIDTH-1:0] read_reg_addr_2,
  output logic                      hazard_1,
  output logic                      hazard_2,
  input  logic [REG_ADDR_WIDTH-1:0] hazard_rd,
  output logic                      hazard_waw,
  output logic                      RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] write_reg_data,
  output logic                      proto_err
);

  localparam int PQ_AW = $clog2(PQ_DEPTH);
  localparam int RB_AW = $clog2(RB_DEPTH);
  localparam logic [PQ_AW:0] PQ_FULL_CNT = (PQ_AW + 1)'(PQ_DEPTH);
  localparam logic [RB_AW:0] RB_FULL_CNT = (RB_AW + 1)'(RB_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REG_ADDR_WIDTH-1:0] pq_rd_q   [PQ_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rb_rd_q   [RB_DEPTH];
  logic [REG_DATA_WIDTH-1:0] rb_data_q [RB_DEPTH];

  logic [PQ_AW-1:0] pq_head_q,  pq_head_d;
  logic [PQ_AW-1:0] pq_tail_q,  pq_tail_d;
  logic [PQ_AW:0]   pq_count_q, pq_count_d;
  logic [RB_AW-1:0] rb_head_q,  rb_head_d;
  logic [RB_AW-1:0] rb_tail_q,  rb_tail_d;
  logic [RB_AW:0]   rb_count_q, rb_count_d;

  logic                      regwrite_q,  regwrite_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
  logic [REG_DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic                      proto_err_q, proto_err_d;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  logic pq_full, pq_empty, rb_full, rb_empty;
  logic mem_hs, pq_pop, pq_push, rb_push, rb_pop;

  logic                      sel_valid;
  logic [REG_ADDR_WIDTH-1:0] sel_rd;
  logic [REG_DATA_WIDTH-1:0] sel_data;

  assign pq_full  = (pq_count_q == PQ_FULL_CNT);
  assign pq_empty = (pq_count_q == '0);
  assign rb_full  = (rb_count_q == RB_FULL_CNT);
  assign rb_empty = (rb_count_q == '0);

  assign mem_hs  = mem_valid && !rb_full;
  // A return with nothing pending has no destination: it is dropped.
  assign pq_pop  = mem_hs && !pq_empty;
  // On a full PQ a same-cycle pop frees the slot the push needs.
  assign pq_push = load_issue && (!pq_full || pq_pop);
  assign rb_push = pq_pop;
  // ALU owns the write port whenever it is valid; RB drains otherwise.
  assign rb_pop  = !alu_valid && !rb_empty;

  assign sel_valid = alu_valid || !rb_empty;
  assign sel_rd    = alu_valid ? alu_rd   : rb_rd_q[rb_head_q];
  assign sel_data  = alu_valid ? alu_data : rb_data_q[rb_head_q];

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    pq_head_d   = pq_head_q;
    pq_tail_d   = pq_tail_q;
    rb_head_d   = rb_head_q;
    rb_tail_d   = rb_tail_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (pq_push) pq_tail_d = pq_tail_q + PQ_AW'(1);
    if (pq_pop)  pq_head_d = pq_head_q + PQ_AW'(1);
    if (rb_push) rb_tail_d = rb_tail_q + RB_AW'(1);
    if (rb_pop)  rb_head_d = rb_head_q + RB_AW'(1);

    pq_count_d = pq_count_q + {{PQ_AW{1'b0}}, pq_push} - {{PQ_AW{1'b0}}, pq_pop};
    rb_count_d = rb_count_q + {{RB_AW{1'b0}}, rb_push} - {{RB_AW{1'b0}}, rb_pop};

    // rd 0 is consumed from its source but never written.
    regwrite_d = sel_valid && (sel_rd != '0);
    if (sel_valid) begin
      wr_addr_d = sel_rd;
      wr_data_d = sel_data;
    end

    proto_err_d = proto_err_q || (mem_hs && pq_empty);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pq_head_q   <= '0;
      pq_tail_q   <= '0;
      pq_count_q  <= '0;
      rb_head_q   <= '0;
      rb_tail_q   <= '0;
      rb_count_q  <= '0;
      regwrite_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pq_head_q   <= pq_head_d;
      pq_tail_q   <= pq_tail_d;
      pq_count_q  <= pq_count_d;
      rb_head_q   <= rb_head_d;
      rb_tail_q   <= rb_tail_d;
      rb_count_q  <= rb_count_d;
      regwrite_q  <= regwrite_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: queue storage has no reset; an entry is only ever read or matched
  // while the occupancy counter says it is live, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (pq_push) pq_rd_q[pq_tail_q] <= load_issue_rd;
    if (rb_push) begin
      rb_rd_q[rb_tail_q]   <= pq_rd_q[pq_head_q];
      rb_data_q[rb_tail_q] <= mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic [PQ_DEPTH-1:0] pq_vld;
  logic [RB_DEPTH-1:0] rb_vld;
  logic [PQ_AW-1:0]    pq_off;
  logic [RB_AW-1:0]    rb_off;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pq_vld = '0;
    rb_vld = '0;
    pq_off = '0;
    rb_off = '0;
    for (int i = 0; i < PQ_DEPTH; i++) begin
      pq_off    = PQ_AW'(i) - pq_head_q;
      pq_vld[i] = ({1'b0, pq_off} < pq_count_q);
    end
    for (int i = 0; i < RB_DEPTH; i++) begin
      rb_off    = RB_AW'(i) - rb_head_q;
      rb_vld[i] = ({1'b0, rb_off} < rb_count_q);
    end
  end

  logic pend_1, pend_2, pend_w;

  always_comb begin
    pend_1 = 1'b0;
    pend_2 = 1'b0;
    pend_w = 1'b0;
    for (int i = 0; i < PQ_DEPTH; i++) begin
      if (pq_vld[i] && pq_rd_q[i] == read_reg_addr_1) pend_1 = 1'b1;
      if (pq_vld[i] && pq_rd_q[i] == read_reg_addr_2) pend_2 = 1'b1;
      if (pq_vld[i] && pq_rd_q[i] == hazard_rd)       pend_w = 1'b1;
    end
    for (int i = 0; i < RB_DEPTH; i++) begin
      if (rb_vld[i] && rb_rd_q[i] == read_reg_addr_1) pend_1 = 1'b1;
      if (rb_vld[i] && rb_rd_q[i] == read_reg_addr_2) pend_2 = 1'b1;
      if (rb_vld[i] && rb_rd_q[i] == hazard_rd)       pend_w = 1'b1;
    end
  end

  // The output stage counts for reads because the register file writes and
  // reads on the same edge; it does not count for WAW since it is already
  // older than anything in decode and commits this cycle.
  assign hazard_1   = (read_reg_addr_1 != '0) &&
                      (pend_1 || (regwrite_q && wr_addr_q == read_reg_addr_1));
  assign hazard_2   = (read_reg_addr_2 != '0) &&
                      (pend_2 || (regwrite_q && wr_addr_q == read_reg_addr_2));
  assign hazard_waw = (hazard_rd != '0) && pend_w;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign issue_stall    = pq_full;
  assign mem_ready      = !rb_full;
  assign RegWrite       = regwrite_q;
  assign write_reg_addr = wr_addr_q;
  assign write_reg_data = wr_data_q;
  assign proto_err      = proto_err_q;

endmodule
